// File: rtl/dcache_ctrl_pkg.sv
// ---- dcache_ctrl_pkg : shared geometry and FSM encoding for the data cache (rev 1.0) ----
`default_nettype none

package dcache_ctrl_pkg;

  localparam int SIZE     = 32;
  localparam int LINES    = 16;
  localparam int WORDS    = 4;
  localparam int OFFSET_W = $clog2(WORDS);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = SIZE - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ---- dcache_array : valid/tag/data storage with combinational lookup (rev 1.0) ----
`default_nettype none

module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter  int SIZE     = dcache_ctrl_pkg::SIZE,
  parameter  int LINES    = dcache_ctrl_pkg::LINES,
  parameter  int WORDS    = dcache_ctrl_pkg::WORDS,
  localparam int OFFSET_W = $clog2(WORDS),
  localparam int INDEX_W  = $clog2(LINES),
  localparam int TAG_W    = SIZE - INDEX_W - OFFSET_W - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [TAG_W-1:0]    tag,
  output logic                match,
  output logic [SIZE-1:0]     word,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [SIZE-1:0]     wr_data,
  input  logic                validate
);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [SIZE-1:0]  data [LINES][WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (validate) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (validate) begin
      tags[index] <= tag;
    end
    if (word_we) begin
      data[index][wr_offset] <= wr_data;
    end
  end

  assign match = valid[index] && (tags[index] == tag);
  assign word  = data[index][offset];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ---- dcache_ctrl : direct-mapped, write-through, no-write-allocate D-cache controller (rev 1.0) ----
`default_nettype none

module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter  int SIZE     = dcache_ctrl_pkg::SIZE,
  parameter  int LINES    = dcache_ctrl_pkg::LINES,
  parameter  int WORDS    = dcache_ctrl_pkg::WORDS,
  localparam int OFFSET_W = $clog2(WORDS),
  localparam int INDEX_W  = $clog2(LINES),
  localparam int TAG_W    = SIZE - INDEX_W - OFFSET_W - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [SIZE-1:0] addr,
  input  logic [SIZE-1:0] writeData,
  output logic [SIZE-1:0] readData,
  output logic            hit,
  output logic            mem_req,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  input  logic [SIZE-1:0] mem_rdata,
  input  logic            mem_ready
);

  state_t              state;
  state_t              state_nx;
  logic [OFFSET_W-1:0] count;
  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                match;
  logic [SIZE-1:0]     word;
  logic                word_we;
  logic                validate;
  logic [OFFSET_W-1:0] wr_offset;
  logic [SIZE-1:0]     wr_data;
  logic                last_word;
  logic                unused_lsb;

  assign offset     = addr[OFFSET_W+1:2];
  assign index      = addr[OFFSET_W+2 +: INDEX_W];
  assign tag        = addr[SIZE-1 -: TAG_W];
  assign last_word  = (count == OFFSET_W'(WORDS - 1));
  assign unused_lsb = ^addr[1:0];

  dcache_array #(
    .SIZE  (SIZE),
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .offset    (offset),
    .tag       (tag),
    .match     (match),
    .word      (word),
    .word_we   (word_we),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .validate  (validate)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state != FILL) begin
      count <= '0;
    end else if (mem_ready) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    hit       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    word_we   = 1'b0;
    validate  = 1'b0;
    wr_offset = offset;
    wr_data   = writeData;
    case (state)
      IDLE: begin
        // A store always goes to memory, so it stalls even when both strobes are set.
        hit = !MemWrite && (!MemRead || match);
        if (MemWrite) begin
          state_nx = WRITE;
        end else if (MemRead && !match) begin
          state_nx = FILL;
        end
      end
      FILL: begin
        mem_req   = 1'b1;
        mem_addr  = {tag, index, count, 2'b00};
        wr_offset = count;
        wr_data   = mem_rdata;
        if (mem_ready) begin
          word_we = 1'b1;
          if (last_word) begin
            validate = 1'b1;
            state_nx = DONE;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[SIZE-1:2], 2'b00};
        mem_wdata = writeData;
        if (mem_ready) begin
          word_we  = match;
          state_nx = DONE;
        end
      end
      DONE: begin
        hit      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign readData = match ? word : '0;

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ---- tb_dcache_ctrl : randomized self-checking bench for dcache_ctrl against a memory/cache model (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        hit;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .writeData (writeData),
    .readData  (readData),
    .hit       (hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  int compared = 0;
  int mismatched = 0;

  // Main memory as seen by the DUT, and the bench's own notion of what memory should hold.
  logic [31:0] mem_model [bit [31:0]];
  logic [31:0] ref_mem   [bit [31:0]];
  // Which tag each line should hold (-1 = invalid).
  int          line_tag  [16];

  int          latency = 0;
  int          wait_cnt = 0;
  int          unstable = 0;
  bit          in_req = 0;
  logic [31:0] held_addr, held_wdata;
  logic        held_we;
  logic [31:0] log_addr  [$];
  logic        log_we    [$];
  logic [31:0] log_wdata [$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction

  // Memory responder: one word per request, ready after 'latency' waiting cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst || !mem_req) begin
        in_req   = 0;
        wait_cnt = 0;
      end else begin
        if (!in_req) begin
          in_req     = 1;
          wait_cnt   = 0;
          held_addr  = mem_addr;
          held_we    = mem_we;
          held_wdata = mem_wdata;
        end else if (mem_addr !== held_addr || mem_we !== held_we ||
                     (held_we && mem_wdata !== held_wdata)) begin
          unstable++;
        end
        if (wait_cnt < latency) begin
          wait_cnt++;
        end else begin
          mem_ready = 1'b1;
          in_req    = 0;
          log_addr.push_back(mem_addr);
          log_we.push_back(mem_we);
          log_wdata.push_back(mem_wdata);
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_read(mem_addr);
        end
      end
    end
  end

  // One pipeline access: drive at negedge, wait for hit, sample readData in the completing cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int cycles, output logic [31:0] rdata, output int reqs,
                        output bit exp_hit);
    int n0, idx, tg;
    idx     = int'(a[7:4]);
    tg      = int'(a[31:8]);
    exp_hit = rd && !wr && (line_tag[idx] == tg);
    n0      = log_addr.size();
    @(negedge clk);
    MemRead   = rd;
    MemWrite  = wr;
    addr      = a;
    writeData = d;
    cycles    = 0;
    #1;
    while (hit !== 1'b1 && cycles < 300) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    rdata = readData;
    reqs  = log_addr.size() - n0;
    if (cycles >= 300) begin
      compared++;
      mismatched++;
      $display("FAIL access_timeout: addr=%h got no hit within %0d cycles, required hit", a, cycles);
    end
    if (wr)      ref_mem[{a[31:2], 2'b00}] = d;
    else if (rd) line_tag[idx] = tg;
  endtask

  int          cyc, reqs;
  logic [31:0] rdv;
  bit          eh;

  task automatic test_reset();
    foreach (line_tag[i]) line_tag[i] = -1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    compared++; if (hit !== 1'b1)        begin mismatched++; $display("FAIL reset_hit: got %b required 1", hit); end
    compared++; if (mem_req !== 1'b0)    begin mismatched++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
    compared++; if (mem_we !== 1'b0)     begin mismatched++; $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    compared++; if (mem_addr !== 32'h0)  begin mismatched++; $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    compared++; if (mem_wdata !== 32'h0) begin mismatched++; $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
    compared++; if (readData !== 32'h0)  begin mismatched++; $display("FAIL reset_readData: got %h required 0", readData); end
  endtask

  task automatic test_cold_read();
    for (int i = 0; i < 4; i++) begin
      mem_model[32'h40 + 4 * i] = 32'hA0 + i;
      ref_mem[32'h40 + 4 * i]   = 32'hA0 + i;
    end
    access(1, 0, 32'h40, 0, cyc, rdv, reqs, eh);
    compared++; if (cyc == 0)  begin mismatched++; $display("FAIL cold_stall: got %0d stall cycles required >0", cyc); end
    compared++; if (reqs != 4) begin mismatched++; $display("FAIL cold_reqs: got %0d required 4", reqs); end
    if (reqs == 4) begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (log_addr[log_addr.size() - 4 + i] !== 32'h40 + 4 * i || log_we[log_we.size() - 4 + i] !== 1'b0) begin
          mismatched++;
          $display("FAIL cold_fill_addr%0d: got %h we=%b required %h we=0", i,
                   log_addr[log_addr.size() - 4 + i], log_we[log_we.size() - 4 + i], 32'h40 + 4 * i);
        end
      end
    end
    compared++; if (rdv !== 32'hA0) begin mismatched++; $display("FAIL cold_data: got %h required a0", rdv); end
    access(1, 0, 32'h48, 0, cyc, rdv, reqs, eh);
    compared++; if (cyc != 0 || reqs != 0) begin mismatched++; $display("FAIL warm_hit: got stall=%0d reqs=%0d required 0/0", cyc, reqs); end
    compared++; if (rdv !== 32'hA2) begin mismatched++; $display("FAIL warm_data: got %h required a2", rdv); end
  endtask

  task automatic test_conflict();
    access(1, 0, 32'h140, 0, cyc, rdv, reqs, eh);
    compared++; if (cyc == 0 || reqs != 4) begin mismatched++; $display("FAIL conflict_fill: got stall=%0d reqs=%0d required >0/4", cyc, reqs); end
    if (reqs == 4) begin
      compared++;
      if (log_addr[log_addr.size() - 4] !== 32'h140) begin
        mismatched++; $display("FAIL conflict_addr: got %h required 00000140", log_addr[log_addr.size() - 4]);
      end
    end
    compared++; if (rdv !== ref_read(32'h140)) begin mismatched++; $display("FAIL conflict_data: got %h required %h", rdv, ref_read(32'h140)); end
    access(1, 0, 32'h40, 0, cyc, rdv, reqs, eh);
    compared++; if (reqs != 4) begin mismatched++; $display("FAIL conflict_reread: got %0d reqs required 4", reqs); end
    compared++; if (rdv !== 32'hA0) begin mismatched++; $display("FAIL conflict_reread_data: got %h required a0", rdv); end
  endtask

  task automatic test_write_hit();
    access(0, 1, 32'h44, 32'hDEAD, cyc, rdv, reqs, eh);
    compared++; if (cyc == 0 || reqs != 1) begin mismatched++; $display("FAIL whit_reqs: got stall=%0d reqs=%0d required >0/1", cyc, reqs); end
    if (reqs == 1) begin
      compared++;
      if (log_addr[$] !== 32'h44 || log_we[$] !== 1'b1 || log_wdata[$] !== 32'hDEAD) begin
        mismatched++;
        $display("FAIL whit_bus: got addr=%h we=%b wdata=%h required 44/1/dead", log_addr[$], log_we[$], log_wdata[$]);
      end
    end
    access(1, 0, 32'h44, 0, cyc, rdv, reqs, eh);
    compared++; if (cyc != 0 || reqs != 0) begin mismatched++; $display("FAIL whit_read_hit: got stall=%0d reqs=%0d required 0/0", cyc, reqs); end
    compared++; if (rdv !== 32'hDEAD) begin mismatched++; $display("FAIL whit_data: got %h required dead", rdv); end
  endtask

  task automatic test_write_miss();
    access(0, 1, 32'h200, 32'h1234, cyc, rdv, reqs, eh);
    compared++; if (reqs != 1) begin mismatched++; $display("FAIL wmiss_reqs: got %0d required 1", reqs); end
    if (reqs == 1) begin
      compared++;
      if (log_addr[$] !== 32'h200 || log_we[$] !== 1'b1 || log_wdata[$] !== 32'h1234) begin
        mismatched++;
        $display("FAIL wmiss_bus: got addr=%h we=%b wdata=%h required 200/1/1234", log_addr[$], log_we[$], log_wdata[$]);
      end
    end
    access(1, 0, 32'h200, 0, cyc, rdv, reqs, eh);
    compared++; if (reqs != 4) begin mismatched++; $display("FAIL wmiss_no_allocate: got %0d reqs required 4", reqs); end
    compared++; if (rdv !== 32'h1234) begin mismatched++; $display("FAIL wmiss_data: got %h required 1234", rdv); end
  endtask

  task automatic test_latency();
    int u0;
    u0 = unstable;
    latency = 5;
    access(1, 0, 32'h300, 0, cyc, rdv, reqs, eh);
    compared++; if (reqs != 4) begin mismatched++; $display("FAIL lat_reqs: got %0d required 4", reqs); end
    compared++; if (cyc < 24) begin mismatched++; $display("FAIL lat_stall: got %0d cycles required >=24", cyc); end
    compared++; if (rdv !== ref_read(32'h300)) begin mismatched++; $display("FAIL lat_data: got %h required %h", rdv, ref_read(32'h300)); end
    access(0, 1, 32'h304, 32'h5555_AAAA, cyc, rdv, reqs, eh);
    compared++; if (reqs != 1 || cyc < 6) begin mismatched++; $display("FAIL lat_write: got reqs=%0d stall=%0d required 1/>=6", reqs, cyc); end
    compared++; if (unstable != u0) begin mismatched++; $display("FAIL lat_stable: got %0d unstable cycles required 0", unstable - u0); end
    latency = 0;
  endtask

  task automatic test_reset_mid_fill();
    int n0, guard;
    n0 = log_addr.size();
    @(negedge clk);
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    addr     = 32'h500;
    guard    = 0;
    while (log_addr.size() < n0 + 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    compared++; if (guard >= 100) begin mismatched++; $display("FAIL midfill_progress: got %0d words required 2", log_addr.size() - n0); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    compared++; if (mem_req !== 1'b0)   begin mismatched++; $display("FAIL midfill_req_drop: got %b required 0", mem_req); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL midfill_addr: got %h required 0", mem_addr); end
    foreach (line_tag[i]) line_tag[i] = -1;
    @(negedge clk);
    MemRead = 1'b0;
    rst     = 1'b0;
    access(1, 0, 32'h500, 0, cyc, rdv, reqs, eh);
    compared++; if (reqs != 4) begin mismatched++; $display("FAIL midfill_refill: got %0d reqs required 4", reqs); end
    if (reqs == 4) begin
      compared++;
      if (log_addr[log_addr.size() - 4] !== 32'h500 || log_addr[$] !== 32'h50C) begin
        mismatched++;
        $display("FAIL midfill_addrs: got %h..%h required 500..50c", log_addr[log_addr.size() - 4], log_addr[$]);
      end
    end
    compared++; if (rdv !== ref_read(32'h500)) begin mismatched++; $display("FAIL midfill_data: got %h required %h", rdv, ref_read(32'h500)); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    int sel;
    for (int k = 0; k < 200; k++) begin
      sel     = $urandom_range(0, 99);
      a       = 32'($urandom_range(0, 2) << 8) | 32'($urandom_range(0, 3) << 4) |
                32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
      d       = $urandom;
      latency = $urandom_range(0, 2);
      if (sel < 45) begin
        access(1, 0, a, d, cyc, rdv, reqs, eh);
        compared++;
        if ((cyc == 0) != eh || reqs != (eh ? 0 : 4)) begin
          mismatched++;
          $display("FAIL rnd_read_hit: addr=%h got stall=%0d reqs=%0d required hit=%b", a, cyc, reqs, eh);
        end
        compared++;
        if (rdv !== ref_read(a)) begin
          mismatched++; $display("FAIL rnd_read_data: addr=%h got %h required %h", a, rdv, ref_read(a));
        end
      end else if (sel < 90) begin
        access(sel >= 80, 1, a, d, cyc, rdv, reqs, eh);
        compared++;
        if (reqs != 1) begin
          mismatched++; $display("FAIL rnd_write_reqs: addr=%h got %0d required 1", a, reqs);
        end else if (log_addr[$] !== {a[31:2], 2'b00} || log_we[$] !== 1'b1 || log_wdata[$] !== d) begin
          mismatched++;
          $display("FAIL rnd_write_bus: got addr=%h we=%b wdata=%h required %h/1/%h",
                   log_addr[$], log_we[$], log_wdata[$], {a[31:2], 2'b00}, d);
        end
      end else begin
        access(0, 0, a, d, cyc, rdv, reqs, eh);
        compared++;
        if (cyc != 0 || reqs != 0) begin
          mismatched++; $display("FAIL rnd_idle: got stall=%0d reqs=%0d required 0/0", cyc, reqs);
        end
      end
    end
    latency = 0;
    compared++; if (unstable != 0) begin mismatched++; $display("FAIL rnd_bus_stable: got %0d unstable cycles required 0", unstable); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_read();
    test_conflict();
    test_write_hit();
    test_write_miss();
    test_latency();
    test_reset_mid_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
